mac_result_reader: RTL and testbench



---
 rtl/mma_pkg.sv | 21 ++
 rtl/mac_result_reader.sv | 128 ++++++++++++
 tb/tb_mac_result_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mma_pkg.sv
// Shared definitions for the matrix-multiply result path: default matrix
// geometry, the result-reader state type and the row-major flat index helper.
package mma_pkg;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(N * N);

    typedef enum logic {
        IDLE,
        STREAM
    } reader_state_t;

    // Row-major position of element (i,j) in an n x n matrix.
    function automatic int unsigned flat_idx(input int unsigned i,
                                             input int unsigned j,
                                             input int unsigned n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/mac_result_reader.sv
// Snapshots the mac_array result matrix on a rising edge of done and streams
// it out row-major, one element per valid/ready transfer, with row/col tags
// and a last marker. A done rise that arrives mid-stream is dropped and
// flagged on the sticky overrun output.
module mac_result_reader #(
    parameter int unsigned N      = mma_pkg::N,
    parameter int unsigned DATA_W = mma_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done,
    input  logic [N*N*DATA_W-1:0]   c_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]    out_row,
    output logic [$clog2(N)-1:0]    out_col,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);
    import mma_pkg::*;

    localparam int unsigned CNT_W = $clog2(N * N);
    localparam int unsigned RC_W  = $clog2(N);
    localparam int unsigned LAST  = N * N - 1;

    reader_state_t      state;
    reader_state_t      state_next;
    logic               done_q;
    logic [CNT_W-1:0]   idx;
    logic [DATA_W-1:0]  snapshot [N*N];

    logic               done_rise;
    logic               xfer;
    logic               at_last;
    logic               capture;
    logic               idx_inc;
    logic               drop;

    assign done_rise = done && !done_q;
    assign xfer      = (state == STREAM) && out_ready;
    assign at_last   = (idx == CNT_W'(LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus capture / advance / drop decisions.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        idx_inc    = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (done_rise) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    // A rise landing on the final transfer reloads with no bubble.
                    if (done_rise) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    idx_inc = xfer;
                    drop    = done_rise;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Rise detector, element index, snapshot storage and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q  <= 1'b0;
            idx     <= '0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < N * N; k++) begin
                snapshot[k] <= '0;
            end
        end else begin
            done_q <= done;
            if (capture) begin
                idx <= '0;
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        snapshot[flat_idx(i, j, N)] <=
                            c_flat[flat_idx(i, j, N) * DATA_W +: DATA_W];
                    end
                end
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only; idle outputs are held at zero.
    always_comb begin
        out_valid = (state == STREAM);
        busy      = (state == STREAM);
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state == STREAM) begin
            out_data = snapshot[idx];
            out_row  = RC_W'(idx / CNT_W'(N));
            out_col  = RC_W'(idx % CNT_W'(N));
            out_last = at_last;
        end
    end

endmodule

// File: tb/tb_mac_result_reader.sv
// Randomized directed bench for mac_result_reader. A queue-based reference
// model holds the expected element stream of the current snapshot; every
// transfer is checked against the queue head.
module tb_mac_result_reader;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = N * N * DW;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    row;
        logic [1:0]    col;
        logic          last;
    } elem_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          done;
    logic [MW-1:0] c_flat;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          out_last;
    logic          busy;
    logic          overrun;

    mac_result_reader #(.N(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .c_flat    (c_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    elem_t         q[$];
    logic          m_busy    = 1'b0;
    logic          m_ovr     = 1'b0;
    logic          prev_done = 1'b0;
    int unsigned   n_xfer    = 0;
    logic          stalled   = 1'b0;
    logic [DW-1:0] st_data;
    logic [1:0]    st_row;
    logic [1:0]    st_col;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_matrix();
        logic [MW-1:0] m;
        for (int k = 0; k < N * N; k++) m[k*DW +: DW] = $urandom;
        return m;
    endfunction

    // Check current outputs, drive inputs, advance the model across the next
    // rising edge and return 1 ns after it.
    task automatic cycle(input logic rdy, input logic dn, input logic [MW-1:0] c, input logic rst);
        logic xfer, lastx, rise;
        reset = rst; done = dn; c_flat = c; out_ready = rdy;
        chk("valid", DW'(out_valid), DW'(m_busy));
        chk("busy", DW'(busy), DW'(m_busy));
        chk("overrun", DW'(overrun), DW'(m_ovr));
        if (m_busy) begin
            chk("data", out_data, q[0].data);
            chk("row", DW'(out_row), DW'(q[0].row));
            chk("col", DW'(out_col), DW'(q[0].col));
            chk("last", DW'(out_last), DW'(q[0].last));
        end
        if (stalled) begin
            chk("stall_data", out_data, st_data);
            chk("stall_row", DW'(out_row), DW'(st_row));
            chk("stall_col", DW'(out_col), DW'(st_col));
        end
        stalled = m_busy && !rdy && !rst;
        st_data = out_data; st_row = out_row; st_col = out_col;
        if (rst) begin
            q.delete(); m_busy = 1'b0; m_ovr = 1'b0; prev_done = 1'b0;
        end else begin
            xfer  = m_busy && rdy;
            lastx = xfer && (q.size() == 1);
            rise  = dn && !prev_done;
            prev_done = dn;
            if (xfer) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (rise) begin
                if (!m_busy || lastx) begin
                    for (int k = 0; k < N * N; k++) begin
                        elem_t e;
                        e.data = c[k*DW +: DW];
                        e.row  = 2'(k / N);
                        e.col  = 2'(k % N);
                        e.last = (k == N * N - 1);
                        q.push_back(e);
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_busy = (q.size() != 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [MW-1:0] m0, m1, m7;
        int unsigned   base, cyc;

        for (int k = 0; k < N * N; k++) m7[k*DW +: DW] = 32'h0000_0007;

        // Reset: two cycles, then the documented reset values.
        reset = 1'b1; done = 1'b0; c_flat = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("rst_data", out_data, '0);
        chk("rst_row", DW'(out_row), '0);
        chk("rst_col", DW'(out_col), '0);
        chk("rst_last", DW'(out_last), '0);

        // Basic drain with fixed corner values, ready held high.
        m0 = rand_matrix();
        m0[0*DW +: DW] = 32'd45; m0[1*DW +: DW] = 32'd92; m0[15*DW +: DW] = 32'd51;
        cycle(1'b1, 1'b1, m0, 1'b0);
        chk("basic_first", out_data, 32'd45);
        base = n_xfer;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, rand_matrix(), 1'b0);
        chk("basic_count", n_xfer - base, 32'd16);

        // Backpressure: ready pattern 1,0,0,1.
        m0 = rand_matrix();
        cycle(1'b0, 1'b1, m0, 1'b0);
        cyc = 0; base = n_xfer;
        while (m_busy && cyc < 200) begin
            cycle((cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, rand_matrix(), 1'b0);
            cyc++;
        end
        chk("bp_count", n_xfer - base, 32'd16);
        chk("bp_timeout", DW'(m_busy), '0);

        // Overrun: second rise after five transfers is dropped.
        m0 = rand_matrix(); m1 = rand_matrix();
        cycle(1'b1, 1'b1, m0, 1'b0);
        cycle(1'b1, 1'b0, m0, 1'b0);
        base = n_xfer; cyc = 0;
        while (n_xfer - base < 4 && cyc < 50) begin cycle(1'b1, 1'b0, m0, 1'b0); cyc++; end
        cycle(1'b1, 1'b1, m1, 1'b0);
        chk("ovr_flag", DW'(overrun), 32'd1);
        cyc = 0;
        while (m_busy && cyc < 50) begin cycle(1'b1, 1'b0, m1, 1'b0); cyc++; end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, m1, 1'b0);
        chk("ovr_sticky", DW'(overrun), 32'd1);

        // Back-to-back: new rise on the last transfer.
        cycle(1'b0, 1'b0, '0, 1'b1);
        m0 = rand_matrix();
        cycle(1'b1, 1'b1, m0, 1'b0);
        cycle(1'b1, 1'b0, m0, 1'b0);
        cyc = 0;
        while (q.size() > 1 && cyc < 50) begin cycle(1'b1, 1'b0, m0, 1'b0); cyc++; end
        cycle(1'b1, 1'b1, m7, 1'b0);
        chk("b2b_valid", DW'(out_valid), 32'd1);
        chk("b2b_data", out_data, 32'd7);
        chk("b2b_row", DW'(out_row), '0);
        chk("b2b_col", DW'(out_col), '0);
        chk("b2b_ovr", DW'(overrun), '0);
        cyc = 0;
        while (m_busy && cyc < 50) begin cycle(1'b1, 1'b0, m7, 1'b0); cyc++; end

        // Long done: one capture for 40 cycles of done high.
        cycle(1'b1, 1'b0, m7, 1'b0);
        m0 = rand_matrix(); base = n_xfer;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, m0, 1'b0);
        cycle(1'b1, 1'b0, m0, 1'b0);
        chk("long_count", n_xfer - base, 32'd16);
        chk("long_busy", DW'(busy), '0);

        // Reset mid-stream after eight transfers, then restart.
        m0 = rand_matrix();
        cycle(1'b1, 1'b1, m0, 1'b0);
        base = n_xfer; cyc = 0;
        while (n_xfer - base < 8 && cyc < 50) begin cycle(1'b1, 1'b0, m0, 1'b0); cyc++; end
        cycle(1'b1, 1'b0, m0, 1'b1);
        chk("mid_valid", DW'(out_valid), '0);
        chk("mid_busy", DW'(busy), '0);
        chk("mid_ovr", DW'(overrun), '0);
        m1 = rand_matrix();
        cycle(1'b1, 1'b1, m1, 1'b0);
        chk("restart_data", out_data, m1[0 +: DW]);
        chk("restart_row", DW'(out_row), '0);
        cyc = 0;
        while (m_busy && cyc < 50) begin cycle($urandom_range(0, 1) == 1, 1'b0, rand_matrix(), 1'b0); cyc++; end
        chk("final_idle", DW'(m_busy), '0);
        cycle(1'b1, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
